// File: rtl/mfp_irq_ctrl.sv
// ---------------------------------------------------------------------------
// mfp_irq_ctrl -- interrupt sequencer for the MFP (68901) model.
//
// This block latches rising edges on 16 interrupt sources into the pending
// register (ipr). It applies the enable (ier) and mask (imr) registers and
// compares the highest masked pending source against the highest in-service
// source. It drives a registered, active-low request to the CPU. It also runs
// the IACK handshake that returns {vector base, source index} with dtack.
//
// mfp_hbit16 (also in this file) finds the highest set bit of a 16-bit word.
//
// Ports
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   src      in   [15:0] source levels, polarity corrected (bit 15 highest)
//   ier      in   [15:0] interrupt enable register
//   imr      in   [15:0] interrupt mask register
//   vr       in   [7:0]  vector register: [7:4] base, [3] S (1 = software EOI)
//   ipr_clr  in   [15:0] one-cycle strobe, 1-bits clear pending
//   isr_clr  in   [15:0] one-cycle strobe, 1-bits clear in-service
//   iack     in   CPU interrupt-acknowledge cycle for this MFP (level)
//   irq_n    out  interrupt request, active low, registered
//   vec      out  [7:0] interrupt vector, valid while dtack=1
//   dtack    out  vector valid / bus acknowledge
//   ipr      out  [15:0] pending register
//   isr      out  [15:0] in-service register
// ---------------------------------------------------------------------------

module mfp_hbit16 (
    input  logic [15:0] bits,
    output logic [3:0]  index,
    output logic        found
);
    // The loop runs upward, so the highest set bit is the last one written.
    always_comb begin
        index = 4'd0;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (bits[i]) begin
                index = 4'(i);
                found = 1'b1;
            end
        end
    end
endmodule

module mfp_irq_ctrl #(
    parameter int ACK_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] src,
    input  logic [15:0] ier,
    input  logic [15:0] imr,
    input  logic [7:0]  vr,
    input  logic [15:0] ipr_clr,
    input  logic [15:0] isr_clr,
    input  logic        iack,
    output logic        irq_n,
    output logic [7:0]  vec,
    output logic        dtack,
    output logic [15:0] ipr,
    output logic [15:0] isr
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_SPUR
    } state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [3:0]  idx, idx_next;
    logic        ack_fire;

    logic [15:0] src_s1, src_s2;
    logic [15:0] rise;
    logic [15:0] masked;
    logic [3:0]  p_idx, s_idx;
    logic        p_found, s_found;
    logic        req;
    logic [15:0] ack_onehot;
    logic [15:0] ipr_next, isr_next;
    logic [2:0]  vr_unused;

    // vr[2:0] carries no meaning for the interrupt logic.
    assign vr_unused = vr[2:0];

    // The edge is taken between two registered samples. This places the
    // pending set one clock after src is sampled.
    assign rise   = src_s1 & ~src_s2;
    assign masked = ipr & imr;

    mfp_hbit16 u_pend_hbit (
        .bits  (masked),
        .index (p_idx),
        .found (p_found)
    );

    mfp_hbit16 u_serv_hbit (
        .bits  (isr),
        .index (s_idx),
        .found (s_found)
    );

    // A source can only interrupt a strictly lower in-service level.
    assign req = p_found && (!s_found || (p_idx > s_idx));

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        ack_fire   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (iack) begin
                    if (req) begin
                        idx_next   = p_idx;
                        cnt_next   = 4'(ACK_WAIT - 1);
                        state_next = ST_WAIT;
                    end else begin
                        state_next = ST_SPUR;
                    end
                end
            end
            ST_WAIT: begin
                if (!iack) begin
                    state_next = ST_IDLE;
                end else if (cnt == 4'd0) begin
                    ack_fire   = 1'b1;
                    state_next = ST_ACK;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ST_ACK: begin
                if (!iack) state_next = ST_IDLE;
            end
            ST_SPUR: begin
                if (!iack) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign ack_onehot = ack_fire ? (16'h0001 << idx) : 16'h0000;

    // A new edge wins over a clear (CPU or acknowledge) on the same bit.
    // A disabled source never stays pending.
    assign ipr_next = ((ipr & ~ipr_clr & ~ack_onehot) | rise) & ier;

    // With automatic EOI (S=0), the in-service register is held empty.
    assign isr_next = vr[3] ? ((isr | ack_onehot) & ~isr_clr) : 16'h0000;

    assign dtack = (state == ST_ACK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= 4'd0;
            idx    <= 4'd0;
            src_s1 <= 16'h0000;
            src_s2 <= 16'h0000;
            ipr    <= 16'h0000;
            isr    <= 16'h0000;
            irq_n  <= 1'b1;
            vec    <= 8'h00;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            idx    <= idx_next;
            src_s1 <= src;
            src_s2 <= src_s1;
            ipr    <= ipr_next;
            isr    <= isr_next;
            irq_n  <= ~req;
            if (ack_fire) vec <= {vr[7:4], idx};
        end
    end
endmodule

// File: tb/tb_mfp_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mfp_irq_ctrl -- self-checking bench for mfp_irq_ctrl.
//
// Directed scenarios check hard-coded expectations. A randomized run then
// compares every output, every cycle, against a behavioural model. The model
// tracks pending/in-service as bit sets and handshake phases as integers.
// ---------------------------------------------------------------------------
module tb_mfp_irq_ctrl;
    localparam int AW = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] src, ier, imr, ipr_clr, isr_clr;
    logic [7:0]  vr;
    logic        iack;
    logic        irq_n, dtack;
    logic [7:0]  vec;
    logic [15:0] ipr, isr;

    int total = 0;
    int bad   = 0;

    mfp_irq_ctrl #(.ACK_WAIT(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .src     (src),
        .ier     (ier),
        .imr     (imr),
        .vr      (vr),
        .ipr_clr (ipr_clr),
        .isr_clr (isr_clr),
        .iack    (iack),
        .irq_n   (irq_n),
        .vec     (vec),
        .dtack   (dtack),
        .ipr     (ipr),
        .isr     (isr)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [15:0] m_h1, m_h2, m_ipr, m_isr;
    logic        m_irq_n;
    logic [7:0]  m_vec;
    int          m_phase;   // 0 idle, 1 waiting, 2 acknowledged, 3 spurious
    int          m_remain;  // wait clocks left before the vector is driven
    int          m_idx;

    function automatic int top_bit(input logic [15:0] v);
        int r = -1;
        for (int i = 0; i < 16; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic model_step();
        int p, s, nphase;
        bit want, fire, rose, keep;
        logic [15:0] nipr, nisr;
        if (reset) begin
            m_h1 = 0; m_h2 = 0; m_ipr = 0; m_isr = 0;
            m_irq_n = 1'b1; m_vec = 8'h00; m_phase = 0; m_remain = 0; m_idx = 0;
            return;
        end
        p = top_bit(m_ipr & imr);
        s = top_bit(m_isr);
        want = (p >= 0) && (s < 0 || p > s);
        fire = 1'b0;
        nphase = m_phase;
        case (m_phase)
            0: if (iack) begin
                   if (want) begin m_idx = p; m_remain = AW; nphase = 1; end
                   else nphase = 3;
               end
            1: if (!iack) nphase = 0;
               else begin
                   m_remain = m_remain - 1;
                   if (m_remain == 0) begin fire = 1'b1; nphase = 2; end
               end
            default: if (!iack) nphase = 0;
        endcase
        for (int i = 0; i < 16; i++) begin
            rose = m_h1[i] && !m_h2[i];
            keep = m_ipr[i] && !ipr_clr[i] && !(fire && i == m_idx);
            nipr[i] = ier[i] && (rose || keep);
            nisr[i] = vr[3] && (m_isr[i] || (fire && i == m_idx)) && !isr_clr[i];
        end
        m_irq_n = !want;
        if (fire) m_vec = {vr[7:4], 4'(m_idx)};
        m_h2 = m_h1;
        m_h1 = src;
        m_ipr = nipr;
        m_isr = nisr;
        m_phase = nphase;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        reset = 1; src = 0; ier = 0; imr = 0; vr = 0; ipr_clr = 0; isr_clr = 0; iack = 0;
        ticks(2);
        total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL reset_irq_n got=%b want=1", irq_n); end
        total++; if (dtack !== 1'b0) begin bad++; $display("FAIL reset_dtack got=%b want=0", dtack); end
        total++; if (ipr !== 16'h0) begin bad++; $display("FAIL reset_ipr got=%h want=0000", ipr); end
        total++; if (isr !== 16'h0) begin bad++; $display("FAIL reset_isr got=%h want=0000", isr); end
        total++; if (vec !== 8'h00) begin bad++; $display("FAIL reset_vec got=%h want=00", vec); end
        reset = 0;
        tick();
    endtask

    task automatic test_basic_ack();
        ier = 16'h0020; imr = 16'h0020; vr = 8'h48;
        src = 16'h0020;
        tick();
        tick();
        total++; if (ipr !== 16'h0020) begin bad++; $display("FAIL basic_ipr got=%h want=0020", ipr); end
        total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL basic_irq_early got=%b want=1", irq_n); end
        tick();
        total++; if (irq_n !== 1'b0) begin bad++; $display("FAIL basic_irq got=%b want=0", irq_n); end
        iack = 1;
        ticks(2);
        total++; if (dtack !== 1'b0) begin bad++; $display("FAIL basic_dtack_early got=%b want=0", dtack); end
        tick();
        total++; if (dtack !== 1'b1) begin bad++; $display("FAIL basic_dtack got=%b want=1", dtack); end
        total++; if (vec !== 8'h45) begin bad++; $display("FAIL basic_vec got=%h want=45", vec); end
        total++; if (ipr !== 16'h0) begin bad++; $display("FAIL basic_ipr_ack got=%h want=0000", ipr); end
        total++; if (isr !== 16'h0020) begin bad++; $display("FAIL basic_isr got=%h want=0020", isr); end
        tick();
        total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL basic_irq_release got=%b want=1", irq_n); end
        total++; if (dtack !== 1'b1) begin bad++; $display("FAIL basic_dtack_hold got=%b want=1", dtack); end
        iack = 0;
        tick();
        total++; if (dtack !== 1'b0) begin bad++; $display("FAIL basic_dtack_drop got=%b want=0", dtack); end
        total++; if (vec !== 8'h45) begin bad++; $display("FAIL basic_vec_hold got=%h want=45", vec); end
    endtask

    task automatic test_nesting();
        ier = 16'hFFFF; imr = 16'hFFFF;
        src = 16'h0028;
        ticks(2);
        total++; if (ipr !== 16'h0008) begin bad++; $display("FAIL nest_ipr got=%h want=0008", ipr); end
        tick();
        total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL nest_blocked got=%b want=1", irq_n); end
        isr_clr = 16'h0020;
        tick();
        isr_clr = 0;
        total++; if (isr !== 16'h0) begin bad++; $display("FAIL nest_isr_clr got=%h want=0000", isr); end
        total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL nest_irq_lag got=%b want=1", irq_n); end
        tick();
        total++; if (irq_n !== 1'b0) begin bad++; $display("FAIL nest_irq_after_clr got=%b want=0", irq_n); end
        iack = 1;
        ticks(3);
        total++; if (vec !== 8'h43) begin bad++; $display("FAIL nest_vec3 got=%h want=43", vec); end
        total++; if (isr !== 16'h0008) begin bad++; $display("FAIL nest_isr3 got=%h want=0008", isr); end
        iack = 0;
        tick();
        src = 16'h00A8;
        ticks(3);
        total++; if (irq_n !== 1'b0) begin bad++; $display("FAIL nest_higher got=%b want=0", irq_n); end
        total++; if (isr !== 16'h0008) begin bad++; $display("FAIL nest_isr_kept got=%h want=0008", isr); end
        ipr_clr = 16'hFFFF; isr_clr = 16'hFFFF;
        tick();
        ipr_clr = 0; isr_clr = 0;
        ticks(2);
    endtask

    task automatic test_auto_eoi();
        vr = 8'h40;
        src = 16'h20A8;
        ticks(2);
        total++; if (ipr !== 16'h2000) begin bad++; $display("FAIL eoi_ipr got=%h want=2000", ipr); end
        tick();
        total++; if (irq_n !== 1'b0) begin bad++; $display("FAIL eoi_irq got=%b want=0", irq_n); end
        iack = 1;
        ticks(3);
        total++; if (dtack !== 1'b1) begin bad++; $display("FAIL eoi_dtack got=%b want=1", dtack); end
        total++; if (vec !== 8'h4D) begin bad++; $display("FAIL eoi_vec got=%h want=4d", vec); end
        total++; if (isr !== 16'h0) begin bad++; $display("FAIL eoi_isr got=%h want=0000", isr); end
        iack = 0;
        tick();
        total++; if (vec !== 8'h4D) begin bad++; $display("FAIL eoi_vec_hold got=%h want=4d", vec); end
    endtask

    task automatic test_back_to_back();
        vr = 8'h40;
        src = 16'h22AC;
        ticks(2);
        total++; if (ipr !== 16'h0204) begin bad++; $display("FAIL b2b_ipr got=%h want=0204", ipr); end
        tick();
        iack = 1;
        ticks(3);
        total++; if (vec !== 8'h49) begin bad++; $display("FAIL b2b_vec9 got=%h want=49", vec); end
        total++; if (ipr !== 16'h0004) begin bad++; $display("FAIL b2b_ipr_left got=%h want=0004", ipr); end
        iack = 0;
        tick();
        iack = 1;
        ticks(3);
        total++; if (dtack !== 1'b1) begin bad++; $display("FAIL b2b_dtack2 got=%b want=1", dtack); end
        total++; if (vec !== 8'h42) begin bad++; $display("FAIL b2b_vec2 got=%h want=42", vec); end
        iack = 0;
        tick();
    endtask

    task automatic test_set_beats_clear_spur();
        src = 16'h22BC;
        tick();
        ipr_clr = 16'h0010;
        tick();
        ipr_clr = 0;
        total++; if (ipr !== 16'h0010) begin bad++; $display("FAIL sbc_ipr got=%h want=0010", ipr); end
        imr = 16'h0000;
        ticks(2);
        total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL spur_irq got=%b want=1", irq_n); end
        iack = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (dtack !== 1'b0) begin bad++; $display("FAIL spur_dtack cyc=%0d got=%b want=0", i, dtack); end
        end
        total++; if (ipr !== 16'h0010) begin bad++; $display("FAIL spur_ipr got=%h want=0010", ipr); end
        iack = 0;
        tick();
        imr = 16'hFFFF;
    endtask

    task automatic test_reset_mid();
        ticks(2);
        total++; if (irq_n !== 1'b0) begin bad++; $display("FAIL rmid_irq got=%b want=0", irq_n); end
        iack = 1;
        ticks(2);
        reset = 1; src = 0;
        tick();
        total++; if (dtack !== 1'b0) begin bad++; $display("FAIL rwait_dtack got=%b want=0", dtack); end
        total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL rwait_irq got=%b want=1", irq_n); end
        total++; if (ipr !== 16'h0) begin bad++; $display("FAIL rwait_ipr got=%h want=0000", ipr); end
        total++; if (vec !== 8'h00) begin bad++; $display("FAIL rwait_vec got=%h want=00", vec); end
        reset = 0; iack = 0;
        tick();
        vr = 8'h48; src = 16'h0002;
        ticks(3);
        iack = 1;
        ticks(3);
        total++; if (vec !== 8'h41) begin bad++; $display("FAIL rack_vec got=%h want=41", vec); end
        total++; if (isr !== 16'h0002) begin bad++; $display("FAIL rack_isr got=%h want=0002", isr); end
        reset = 1;
        tick();
        total++; if (dtack !== 1'b0) begin bad++; $display("FAIL rack_dtack got=%b want=0", dtack); end
        total++; if (isr !== 16'h0) begin bad++; $display("FAIL rack_isr_rst got=%h want=0000", isr); end
        total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL rack_irq got=%b want=1", irq_n); end
        reset = 0; src = 0; iack = 0;
        tick();
    endtask

    // ---------------- randomized run against the model ----------------
    task automatic test_random();
        reset = 1; src = 0; ier = 16'hFFFF; imr = 16'hFFFF; vr = 8'h58;
        ipr_clr = 0; isr_clr = 0; iack = 0;
        tick();
        reset = 0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 2) == 0) src = src ^ 16'(1 << $urandom_range(0, 15));
            if ($urandom_range(0, 79) == 0) ier = 16'($urandom) | 16'($urandom);
            if ($urandom_range(0, 79) == 0) imr = 16'($urandom) | 16'($urandom);
            if ($urandom_range(0, 149) == 0) vr = 8'($urandom);
            ipr_clr = ($urandom_range(0, 7) == 0) ? (16'($urandom) & 16'($urandom)) : 16'h0;
            isr_clr = ($urandom_range(0, 7) == 0) ? (16'($urandom) & 16'($urandom)) : 16'h0;
            if ($urandom_range(0, 4) == 0) iack = ~iack;
            tick();
            total++; if (irq_n !== m_irq_n) begin bad++; $display("FAIL rnd_irq_n cyc=%0d got=%b want=%b", c, irq_n, m_irq_n); end
            total++; if (dtack !== (m_phase == 2)) begin bad++; $display("FAIL rnd_dtack cyc=%0d got=%b want=%b", c, dtack, (m_phase == 2)); end
            total++; if (vec !== m_vec) begin bad++; $display("FAIL rnd_vec cyc=%0d got=%h want=%h", c, vec, m_vec); end
            total++; if (ipr !== m_ipr) begin bad++; $display("FAIL rnd_ipr cyc=%0d got=%h want=%h", c, ipr, m_ipr); end
            total++; if (isr !== m_isr) begin bad++; $display("FAIL rnd_isr cyc=%0d got=%h want=%h", c, isr, m_isr); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_ack();
        test_nesting();
        test_auto_eoi();
        test_back_to_back();
        test_set_beats_clear_spur();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
